// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
// Holds the default word width, the minimum legal period, the period clamp
// helper and the counter/duty word type.
package pwm_pkg;

  // Default width of the period counter, period and duty values.
  localparam int unsigned DefCntW = 16;

  // Shortest period the counter can run; smaller requests are raised to this.
  localparam int unsigned MinPeriod = 2;

  // Counter / duty word at the default width.
  typedef logic [DefCntW-1:0] pwm_word_t;

  // Raise a requested period to the minimum. There is no upper clamp.
  // Callers widen their value to 32 bits and truncate the result back.
  function automatic logic [31:0] clamp_period(input logic [31:0] period);
    return (period < MinPeriod) ? 32'(MinPeriod) : period;
  endfunction

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM compare channel.
// Keeps a staged duty (written by load) and an active duty (copied from the
// staged value on apply), and registers en && (cnt < active duty) onto pwm.
// Because pwm is registered it lags the counter by one cycle.
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned DEF_DUTY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic             load,
  input  logic             apply,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             pwm
);

  logic [CNT_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_d;

  // Staging follows load (last write wins); active follows apply. On a
  // simultaneous load and apply the old staged value goes active while the
  // new request is captured, which falls out of the non-blocking update.
  always_comb begin
    stage_d = load ? cfg_duty : stage_q;
    duty_d  = apply ? stage_q : duty_q;
    // duty >= period keeps the output high across the wrap; duty 0 keeps it low
    pwm_d   = en && (cnt < duty_q);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      duty_q  <= CNT_W'(DEF_DUTY);
      pwm     <= 1'b0;
    end else begin
      stage_q <= stage_d;
      duty_q  <= duty_d;
      pwm     <= pwm_d;
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with a shared period counter.
// Period and per-channel duty are staged by cfg_load and become active only
// at a period boundary (or immediately while stopped), so outputs never
// glitch mid-period and the counter never overruns a shrunken period.
// Build option: define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned)
// counter with period 2P-2; otherwise the counter is an edge-aligned sawtooth.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned CH         = 4,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned DEF_PERIOD = 32768,
  parameter int unsigned DEF_DUTY   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cfg_load,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CH*CNT_W-1:0] cfg_duty,
  output logic [CH-1:0]       pwm_out,
  output logic                period_end,
  output logic                cfg_pending
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] stage_period_q, stage_period_d;
  logic             pending_q, pending_d;
  logic             period_end_q, period_end_d;
  logic             last_cycle;
  logic             apply;

`ifdef PWM_CENTER_ALIGN_EN
  localparam logic             DirUp   = 1'b0;
  localparam logic             DirDown = 1'b1;
  localparam logic [CNT_W-1:0] Two     = CNT_W'(2);

  logic dir_q, dir_d;

  // Up 0..P-1 then down P-2..1; the period ends on the descending cnt==1,
  // except for P=2 where there is no descending leg and it ends on cnt==1 up.
  always_comb begin
    last_cycle = (cnt_q == One) && ((period_q == Two) || (dir_q == DirDown));
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DirUp;
    end else if (last_cycle) begin
      cnt_d = '0;
      dir_d = DirUp;
    end else if (dir_q == DirUp) begin
      if (cnt_q == period_q - One) begin
        cnt_d = period_q - Two;
        dir_d = DirDown;
      end else begin
        cnt_d = cnt_q + One;
      end
    end else begin
      cnt_d = cnt_q - One;
    end
  end

  // Flag the upcoming last cycle so period_end is registered yet coincident.
  always_comb begin
    period_end_d = en && (cnt_d == One) &&
                   ((period_d == Two) || (dir_d == DirDown));
  end

  // Count direction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DirUp;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  // Sawtooth 0..P-1; the period ends on cnt==P-1.
  always_comb begin
    last_cycle = (cnt_q == period_q - One);
    if (!en || last_cycle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + One;
    end
  end

  // Flag the upcoming last cycle so period_end is registered yet coincident.
  always_comb begin
    period_end_d = en && (cnt_d == period_d - One);
  end
`endif

  // Config handshake: stage on load, promote at a boundary or while stopped.
  // A load coinciding with an apply re-arms pending for the next boundary.
  always_comb begin
    apply          = pending_q && (!en || last_cycle);
    stage_period_d = stage_period_q;
    if (cfg_load) begin
      stage_period_d = CNT_W'(clamp_period(32'(cfg_period)));
    end
    period_d  = apply ? stage_period_q : period_q;
    pending_d = cfg_load ? 1'b1 : (apply ? 1'b0 : pending_q);
  end

  // Shared counter, period and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      period_q       <= CNT_W'(DEF_PERIOD);
      stage_period_q <= '0;
      pending_q      <= 1'b0;
      period_end_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      stage_period_q <= stage_period_d;
      pending_q      <= pending_d;
      period_end_q   <= period_end_d;
    end
  end

  assign period_end  = period_end_q;
  assign cfg_pending = pending_q;

  // One compare channel per output.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_cmp_ch #(
      .CNT_W    (CNT_W),
      .DEF_DUTY (DEF_DUTY)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .cnt      (cnt_q),
      .load     (cfg_load),
      .apply    (apply),
      .cfg_duty (cfg_duty[i*CNT_W +: CNT_W]),
      .pwm      (pwm_out[i])
    );
  end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
- Multi-channel PWM generator; successor to the single-channel fixed-duty LED dimmer.
- One shared period counter drives CH independent compare channels.
- Period and per-channel duty are run-time programmable, and new values are applied glitch-free at period boundaries.
- Sits between the control/register logic and the LED/motor drive pins.

Parameters:
- CH, 4, number of PWM output channels (1..16).
- CNT_W, 16, width of the period counter, period and duty values.
- DEF_PERIOD, 32768, active period loaded at reset (cycles; must be ≥2 and < 2^CNT_W).
- DEF_DUTY, 0, active duty of every channel at reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable, level sensitive.
- cfg_load  in  1  single-cycle strobe; captures cfg_period and cfg_duty into staging.
- cfg_period  in  CNT_W  requested period in clk cycles.
- cfg_duty  in  CH*CNT_W  requested high-time per channel; channel i is bits [i*CNT_W +: CNT_W].
- pwm_out  out  CH  registered PWM outputs.
- period_end  out  1  one-cycle pulse in the last cycle of each period.
- cfg_pending  out  1  staged values are waiting for a boundary.

Behaviour:
- Reset:
  - cnt=0.
  - active period=DEF_PERIOD; all active duties=DEF_DUTY.
  - staging registers cleared.
  - pwm_out=0, period_end=0, cfg_pending=0.
- Period clamp: a staged period <2 is stored as 2. There is no upper clamp.
- Counter, with en=1:
  - cnt runs 0..P-1, then wraps to 0 (P = active period).
  - period_end (registered) is 1 in the cycle where cnt==P-1.
- Compare:
  - pwm_out[i] <= en && (cnt < duty_i), registered.
  - Output therefore lags cnt by 1 cycle.
  - duty_i=0 gives constant low.
  - duty_i≥P gives constant high, with no glitch at wrap.
- Stop:
  - en=0 forces cnt<=0, pwm_out<=0 and period_end<=0 on the next edge.
  - Re-asserting en restarts from cnt=0, so the first high cycle appears 1 cycle after en rises.
- Config handshake:
  - cfg_load=1 copies cfg_period/cfg_duty into staging and sets cfg_pending.
  - A second cfg_load before a boundary overwrites staging (last write wins).
- Apply:
  - If cfg_pending and (cnt==P-1 with en=1) or en=0, staging is copied to active and cfg_pending clears in the same edge.
  - New values are used from the next cnt=0.
- Simultaneous cfg_load and boundary:
  - The old staging is applied.
  - The new values are captured and cfg_pending stays 1.
  - The new values apply at the following boundary.
- Period shrink: because changes apply only at wrap, cnt never exceeds the new P-1.
- Reset mid-period: all state returns to reset values immediately (asynchronous). Staged config is lost.

Optional Feature:
- Macro: PWM_CENTER_ALIGN_EN.
- Defined:
  - Counter counts up 0..P-1, then down P-2..1; period length 2P-2 cycles.
  - Compare rule is unchanged, so high pulses are centred on cnt=0.
  - period_end and apply occur in the cycle with cnt==1 while counting down. For P=2 they occur at cnt==1 while counting up.
  - An extra direction flop is added, reset to up.
- Undefined: edge-aligned sawtooth only; no direction flop.

Decomposition:
- Package pwm_pkg holds:
  - default CNT_W;
  - the minimum-period constant (2);
  - a clamp function for period;
  - a typedef for the counter/duty word.
- Sub-module pwm_cmp_ch: one per channel via generate. It holds the active/staged duty registers and the registered comparator, and takes cnt, apply and load as inputs.
- The top level holds the counter, period registers, pending flag and (optionally) the direction flop.

Test Plan:
- Default run: reset, en=1 with DEF_DUTY=0 and P=32768 → pwm_out=0 throughout; period_end pulses every 32768 cycles.
- Duty sweep: load P=10 with duties {0,3,10,15} while en=0.
  - Values apply immediately; cfg_pending=0 the next cycle.
  - After en=1, ch0 is always 0, ch1 is high 3 of 10 cycles, ch2 and ch3 are always 1.
  - No glitch at wrap.
- Boundary update: P=10 running, cfg_load P=6 duty 2 at cnt=4.
  - cfg_pending=1 until the edge at cnt==9.
  - The next period is 6 cycles with 2 cycles high.
- Collision: cfg_load in the same cycle as cnt==P-1 → the old staging is applied, cfg_pending stays 1, and the new values take effect one period later.
- Clamp/stop: load P=0 → treated as 2. Drop en mid-period → outputs 0 and cnt 0 the next edge. Assert rst_n low mid-run → all outputs 0 asynchronously.
- (PWM_CENTER_ALIGN_EN) P=5, duty 2 → cnt sequence 0,1,2,3,4,3,2,1 (8 cycles); output high for cnt 0,1 with a 1-cycle lag; period_end at descending cnt==1.
